// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer and the processor it drives.
package program_sequencer_pkg;

  // Default geometry of the program store.
  localparam int INSTR_W_DEF = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int DEPTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  // Sentinel word that terminates a program; it is never issued.
  localparam logic [INSTR_W_DEF-1:0] HALT_CODE_DEF = 8'hFF;

  // Instruction field layout, shared with the processor's control unit.
  localparam int OPCODE_MSB  = 7;
  localparam int OPCODE_LSB  = 4;
  localparam int OPERAND_MSB = 3;
  localparam int OPERAND_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_ADVANCE,
    ST_PAUSE,
    ST_HALT
  } state_e;

endpackage

// File: rtl/program_sequencer_mem.sv
// Program store: register array with one synchronous write port and a
// combinational read port addressed by the program counter.
module program_mem #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  // Contents are deliberately left unreset so a program survives a reset.
  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_sequencer.sv
// Issuing end of the instruction/execute/done handshake: walks a loaded
// program, presents each word with a one-cycle execute strobe and waits for
// done, with single-step, halt sentinel and done watchdog.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int                 DEPTH     = DEPTH_DEF,
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] HALT_CODE = HALT_CODE_DEF,
  parameter int                 TIMEOUT   = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic               done,
  output logic [INSTR_W-1:0] instruction,
  output logic               execute,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               timeout_err
);

  localparam int                WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               terr_q, terr_d;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_we;

  // Loading is only allowed while no program is in flight.
  assign mem_we = load_en && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  program_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(load_addr),
    .wdata_i(load_data),
    .raddr_i(pc_q),
    .rdata_o(mem_rdata)
  );

  // State and datapath registers; reset drops the strobe immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state and datapath updates for the handshake sequence.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wd_d    = wd_q;
    terr_d  = terr_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          terr_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_rdata == HALT_CODE) begin
          state_d = ST_HALT;
        end else begin
          instr_d = mem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // done seen here belongs to a previous instruction and is ignored.
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done) begin
          state_d = ST_ADVANCE;
        end else if (wd_q == WD_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_HALT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_ADVANCE: begin
        // No wrap-around: running off the end of memory halts at the last word.
        if (pc_q == PC_LAST) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = step_mode ? ST_PAUSE : ST_FETCH;
        end
      end
      ST_PAUSE: begin
        if (step) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instruction = instr_q;
  assign execute     = (state_q == ST_ISSUE);
  assign pc          = pc_q;
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE) ||
                       (state_q == ST_ADVANCE) || (state_q == ST_PAUSE);
  assign halted      = (state_q == ST_HALT);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: processor model answering execute with done,
// reference program walk computed from a shadow copy of the program store.
module tb_program_sequencer;

  localparam int         DEPTH   = 16;
  localparam int         TIMEOUT = 64;
  localparam logic [7:0] HALT    = 8'hFF;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       start = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic       done = 1'b0;
  logic [7:0] instruction;
  logic       execute;
  logic [3:0] pc;
  logic       busy;
  logic       halted;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .step_mode  (step_mode),
    .step       (step),
    .done       (done),
    .instruction(instruction),
    .execute    (execute),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_word(input int a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = 4'(a);
    load_data = d;
    tick();
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  function automatic logic [7:0] rand_word();
    logic [7:0] w;
    do w = 8'($urandom); while (w == HALT);
    return w;
  endfunction

  // Processor model plus reference walk: the program runs from first_idx up to
  // the first HALT word (or the whole memory), done follows each execute after
  // dly cycles (random 1..4 when dly is 0).
  task automatic respond(input string tag, input int first_idx, input bit do_start,
                         input bit kick, input int dly);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_exec, exp_pc, cnt, last_done, start_cyc;
    bit first_exec;
    n_exec = DEPTH;
    exp_pc = DEPTH - 1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (model_mem[i] == HALT) begin
        n_exec = i;
        exp_pc = i;
      end
    end
    for (int i = first_idx; i < n_exec; i++) exp_q.push_back(model_mem[i]);
    cnt = kick ? 1 : 0;
    last_done = -1;
    start_cyc = -1;
    first_exec = 1'b1;
    if (do_start) begin
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
    end
    for (int b = 0; b < 3000; b++) begin
      done = 1'b0;
      if (execute) begin
        got_q.push_back(instruction);
        $display("%s: execute pc=%0d instr=%02h cycle=%0d", tag, pc, instruction, cyc);
        if (first_exec && do_start) chk({tag, "_start_lat"}, 32'(cyc - start_cyc), 32'd2);
        else if (last_done >= 0) chk({tag, "_done_lat"}, 32'(cyc - last_done), 32'd3);
        first_exec = 1'b0;
        cnt = (dly > 0) ? dly : int'($urandom_range(1, 4));
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done = 1'b1;
          last_done = cyc;
        end
      end
      if (halted) break;
      tick();
    end
    done = 1'b0;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_instr"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    logic [7:0] orig1;
    logic [7:0] alt;
    int len;

    // Reset state.
    tick();
    tick();
    chk("rst_execute", 32'(execute), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    tick();

    // Three-instruction program, done two cycles after each execute.
    load_word(0, 8'h15);
    load_word(1, 8'h2A);
    load_word(2, 8'h3C);
    load_word(3, HALT);
    respond("three", 0, 1'b1, 1'b0, 2);

    // Step mode on the same program.
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("step_exec0", 32'(execute), 32'd1);
    chk("step_instr0", 32'(instruction), 32'h15);
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
        chk("step_noexec", 32'(execute), 32'd0);
        start = (k == 1);
        tick();
        start = 1'b0;
      end
      chk("step_pause_pc", 32'(pc), 32'(i + 1));
      chk("step_pause_busy", 32'(busy), 32'd1);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_fetch_noexec", 32'(execute), 32'd0);
      tick();
      if (i < 2) begin
        chk("step_exec", 32'(execute), 32'd1);
        chk("step_instr", 32'(instruction), 32'(model_mem[i + 1]));
        $display("step: execute pc=%0d instr=%02h", pc, instruction);
      end else begin
        chk("step_halted", 32'(halted), 32'd1);
        chk("step_end_pc", 32'(pc), 32'd3);
      end
    end
    step_mode = 1'b0;

    // Watchdog: no done after the first execute.
    for (int i = 0; i < 5; i++) load_word(i, rand_word());
    load_word(5, HALT);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("wd_exec", 32'(execute), 32'd1);
    for (int k = 1; k <= TIMEOUT; k++) tick();
    chk("wd_not_yet_halted", 32'(halted), 32'd0);
    chk("wd_not_yet_terr", 32'(timeout_err), 32'd0);
    tick();
    chk("wd_halted", 32'(halted), 32'd1);
    chk("wd_terr", 32'(timeout_err), 32'd1);
    $display("watchdog: timeout_err=%0b halted=%0b", timeout_err, halted);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wd_restart_terr", 32'(timeout_err), 32'd0);
    chk("wd_restart_pc", 32'(pc), 32'd0);
    tick();
    chk("wd_reissue_exec", 32'(execute), 32'd1);
    chk("wd_reissue_instr", 32'(instruction), 32'(model_mem[0]));
    tick();
    respond("wd_rerun", 1, 1'b0, 1'b1, 0);

    // Full memory without a HALT word.
    for (int i = 0; i < DEPTH; i++) load_word(i, rand_word());
    respond("full", 0, 1'b1, 1'b0, 0);

    // Random-length programs with random done delays.
    for (int r = 0; r < 3; r++) begin
      len = int'($urandom_range(1, 15));
      for (int i = 0; i < len; i++) load_word(i, rand_word());
      load_word(len, HALT);
      respond("rand", 0, 1'b1, 1'b0, 0);
    end

    // Handshake hygiene.
    for (int i = 0; i < 4; i++) load_word(i, rand_word());
    load_word(4, HALT);
    orig1 = model_mem[1];
    do alt = rand_word(); while (alt == orig1);
    start = 1'b1;
    tick();
    start = 1'b0;
    done = 1'b1;
    tick();
    chk("hyg_exec0", 32'(execute), 32'd1);
    chk("hyg_instr0", 32'(instruction), 32'(model_mem[0]));
    tick();
    done = 1'b0;
    load_en = 1'b1;
    load_addr = 4'd1;
    load_data = alt;
    start = 1'b1;
    tick();
    load_en = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("hyg_stale_pc", 32'(pc), 32'd0);
      chk("hyg_stale_busy", 32'(busy), 32'd1);
      chk("hyg_stale_exec", 32'(execute), 32'd0);
      tick();
    end
    done = 1'b1;
    tick();
    tick();
    tick();
    done = 1'b0;
    chk("hyg_exec1", 32'(execute), 32'd1);
    chk("hyg_instr1", 32'(instruction), 32'(orig1));
    chk("hyg_pc1", 32'(pc), 32'd1);
    for (int k = 0; k < 3; k++) tick();
    chk("hyg_hold_pc", 32'(pc), 32'd1);
    chk("hyg_hold_busy", 32'(busy), 32'd1);
    respond("hyg_rest", 2, 1'b0, 1'b1, 0);

    // Reset in the middle of the second instruction.
    for (int i = 0; i < 3; i++) load_word(i, rand_word());
    load_word(3, HALT);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    chk("mid_exec1", 32'(execute), 32'd1);
    tick();
    chk("mid_pc_before", 32'(pc), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_exec", 32'(execute), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_instr", 32'(instruction), 32'd0);
    chk("mid_rst_terr", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_idle_busy", 32'(busy), 32'd0);
    chk("mid_idle_exec", 32'(execute), 32'd0);
    respond("mid_rerun", 0, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
